// File: rtl/fm_discriminator_dec_if.sv
// fm_discriminator_dec_if: I/Q sample inputs and discriminator result outputs of fm_discriminator_dec.
//   i_I_data/i_I_valid   signed in-phase sample and its single-cycle strobe
//   i_Q_data/i_Q_valid   signed quadrature sample and its single-cycle strobe
//   o_data               signed discriminator result or decimated sum
//   o_valid              one-cycle strobe qualifying o_data
//   o_overrun            one-cycle pulse when a latched component was overwritten
//   master drives samples, slave (the discriminator) drives results.
interface fm_discriminator_dec_if #(
    parameter int IQ_W       = 16,
    parameter int DECIM_LOG2 = 0
);
    localparam int OUT_W = 2 * IQ_W + 2 + DECIM_LOG2;
    logic signed [IQ_W-1:0]  i_I_data;
    logic                    i_I_valid;
    logic signed [IQ_W-1:0]  i_Q_data;
    logic                    i_Q_valid;
    logic signed [OUT_W-1:0] o_data;
    logic                    o_valid;
    logic                    o_overrun;
    modport master (
        output i_I_data, i_I_valid, i_Q_data, i_Q_valid,
        input  o_data, o_valid, o_overrun
    );
    modport slave (
        input  i_I_data, i_I_valid, i_Q_data, i_Q_valid,
        output o_data, o_valid, o_overrun
    );
endinterface

// File: rtl/fm_discriminator_dec.sv
// fm_discriminator_dec: polar FM discriminator I[n-1]*Q[n] - Q[n-1]*I[n] with I/Q pairing and integrate-and-dump decimation.
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   bus      slave side of fm_discriminator_dec_if (I/Q samples in, result/valid/overrun out)
//   Latency is 3 clocks from pair completion to o_valid; one pair per clock sustained.
module fm_discriminator_dec #(
    parameter int IQ_W       = 16,
    parameter int DECIM_LOG2 = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fm_discriminator_dec_if.slave bus
);
    localparam int PW    = 2 * IQ_W;
    localparam int DW    = 2 * IQ_W + 2;
    localparam int OUT_W = DW + DECIM_LOG2;
    localparam int CW    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

    typedef enum logic {PRIME, RUN} state_t;
    state_t state_q, state_d;

    logic                    have_i_q, have_q_q, have_i_d, have_q_d;
    logic signed [IQ_W-1:0]  ilat_q, qlat_q, icur, qcur, iprev_q, qprev_q;
    logic                    complete, issue, overrun_d, overrun_q;
    logic signed [PW-1:0]    pa_d, pb_d, pa_q, pb_q;
    logic                    v1_q, v2_q, valid_q, last;
    logic signed [DW-1:0]    d_q;
    logic signed [OUT_W-1:0] d_x, sum, acc_q, data_q;
    logic [CW-1:0]           cnt_q;

    always_comb begin
        complete  = (bus.i_I_valid | have_i_q) & (bus.i_Q_valid | have_q_q);
        // An arriving component always replaces the latched one, so the latch tracks the current value.
        icur      = bus.i_I_valid ? bus.i_I_data : ilat_q;
        qcur      = bus.i_Q_valid ? bus.i_Q_data : qlat_q;
        have_i_d  = ~complete & (have_i_q | bus.i_I_valid);
        have_q_d  = ~complete & (have_q_q | bus.i_Q_valid);
        // Any overwrite of a still-latched component loses a sample.
        overrun_d = (bus.i_I_valid & have_i_q) | (bus.i_Q_valid & have_q_q);
        pa_d      = PW'(iprev_q) * PW'(qcur);
        pb_d      = PW'(qprev_q) * PW'(icur);
        d_x       = OUT_W'(d_q);
        sum       = acc_q + d_x;
        last      = (DECIM_LOG2 == 0) || (cnt_q == {CW{1'b1}});
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        if (complete) begin
            state_d = RUN;
            issue   = (state_q == RUN);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= PRIME;
            have_i_q  <= 1'b0;
            have_q_q  <= 1'b0;
            ilat_q    <= '0;
            qlat_q    <= '0;
            iprev_q   <= '0;
            qprev_q   <= '0;
            overrun_q <= 1'b0;
            pa_q      <= '0;
            pb_q      <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            d_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            have_i_q  <= have_i_d;
            have_q_q  <= have_q_d;
            ilat_q    <= icur;
            qlat_q    <= qcur;
            overrun_q <= overrun_d;
            if (complete) begin
                iprev_q <= icur;
                qprev_q <= qcur;
            end
            v1_q    <= issue;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            v2_q    <= v1_q;
            d_q     <= DW'(pa_q) - DW'(pb_q);
            valid_q <= v2_q & last;
            if (v2_q) begin
                acc_q <= last ? '0 : sum;
                cnt_q <= last ? '0 : cnt_q + CW'(1);
                if (last) data_q <= sum;
            end
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_overrun = overrun_q;
endmodule

// File: tb/tb_fm_discriminator_dec.sv
// tb_fm_discriminator_dec: scoreboard bench for fm_discriminator_dec at DECIM_LOG2=0 (dut0) and DECIM_LOG2=2 (dut2).
module tb_fm_discriminator_dec;
    localparam int IQ_W = 16;

    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst2_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        longint data;
        int     cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    int   ov0[$];

    fm_discriminator_dec_if #(.IQ_W(IQ_W), .DECIM_LOG2(0)) if0 ();
    fm_discriminator_dec_if #(.IQ_W(IQ_W), .DECIM_LOG2(2)) if2 ();

    fm_discriminator_dec #(.IQ_W(IQ_W), .DECIM_LOG2(0)) dut0 (
        .i_clk  (clk),
        .i_rst_n(rst0_n),
        .bus    (if0)
    );

    fm_discriminator_dec #(.IQ_W(IQ_W), .DECIM_LOG2(2)) dut2 (
        .i_clk  (clk),
        .i_rst_n(rst2_n),
        .bus    (if2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic spurious(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected strobe at cycle %0d", name, cyc);
    endtask

    // One clock of stimulus: the selected DUT gets the given valids/data, the other is idle.
    task automatic step(input int sel, input logic iv, input int id, input logic qv, input int qd);
        @(posedge clk);
        #1;
        if0.i_I_valid = (sel == 0) & iv;
        if0.i_Q_valid = (sel == 0) & qv;
        if0.i_I_data  = IQ_W'(id);
        if0.i_Q_data  = IQ_W'(qd);
        if2.i_I_valid = (sel == 2) & iv;
        if2.i_Q_valid = (sel == 2) & qv;
        if2.i_I_data  = IQ_W'(id);
        if2.i_Q_data  = IQ_W'(qd);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic exp0(input longint d, input int dly);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + dly;
        q0.push_back(e);
    endtask

    task automatic exp2(input longint d, input int dly);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + dly;
        q2.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   c;
        if (if0.o_valid === 1'b1) begin
            if (q0.size() == 0) spurious("dut0 o_valid");
            else begin
                e = q0.pop_front();
                check("dut0 o_data", longint'(if0.o_data), e.data);
                check("dut0 o_valid cycle", cyc, e.cyc);
            end
        end
        if (if0.o_overrun === 1'b1) begin
            if (ov0.size() == 0) spurious("dut0 o_overrun");
            else begin
                c = ov0.pop_front();
                check("dut0 o_overrun cycle", cyc, c);
            end
        end
        if (if2.o_valid === 1'b1) begin
            if (q2.size() == 0) spurious("dut2 o_valid");
            else begin
                e = q2.pop_front();
                check("dut2 o_data", longint'(if2.o_data), e.data);
                check("dut2 o_valid cycle", cyc, e.cyc);
            end
        end
        if (if2.o_overrun === 1'b1) spurious("dut2 o_overrun");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual cycle %0d required below 20000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ip, qp, ic, qc, c0, r;
        int vi[4] = '{1000, 0, -1000, 0};
        int vq[4] = '{0, 1000, 0, -1000};
        if0.i_I_valid = 1'b0;
        if0.i_Q_valid = 1'b0;
        if0.i_I_data  = '0;
        if0.i_Q_data  = '0;
        if2.i_I_valid = 1'b0;
        if2.i_Q_valid = 1'b0;
        if2.i_I_data  = '0;
        if2.i_Q_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset dut0 o_data", longint'(if0.o_data), 0);
        check("reset dut0 o_valid", longint'(if0.o_valid), 0);
        check("reset dut0 o_overrun", longint'(if0.o_overrun), 0);
        check("reset dut2 o_data", longint'(if2.o_data), 0);
        check("reset dut2 o_valid", longint'(if2.o_valid), 0);
        check("reset dut2 o_overrun", longint'(if2.o_overrun), 0);
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        rst2_n = 1'b1;
        idle(2);

        // Basic rotation: first pair only primes the history.
        step(0, 1'b1, 1000, 1'b1, 0);
        idle(19);
        step(0, 1'b1, 0, 1'b1, 1000);
        exp0(1000000, 3);
        idle(19);
        step(0, 1'b1, -1000, 1'b1, 0);
        exp0(1000000, 3);
        idle(19);
        step(0, 1'b1, 0, 1'b1, 1000);
        exp0(-1000000, 3);
        idle(5);

        // Full-scale extremes.
        step(0, 1'b1, -32768, 1'b1, 32767);
        exp0(32768000, 3);
        idle(4);
        step(0, 1'b1, -32768, 1'b1, -32768);
        exp0(2147450880, 3);
        idle(4);
        step(0, 1'b1, -32768, 1'b1, 32767);
        exp0(-2147450880, 3);
        idle(4);
        step(0, 1'b1, 32767, 1'b1, -32768);
        exp0(65535, 3);
        idle(5);

        // Split valids: I first, Q five cycles later.
        step(0, 1'b1, 100, 1'b0, 0);
        idle(4);
        step(0, 1'b0, 0, 1'b1, 200);
        exp0(9830200, 3);
        idle(5);

        // Overrun: second I overwrites the first and is the one paired.
        step(0, 1'b1, 300, 1'b0, 0);
        c0 = cyc;
        idle(1);
        step(0, 1'b1, -50, 1'b0, 0);
        ov0.push_back(c0 + 3);
        idle(1);
        step(0, 1'b0, 0, 1'b1, 7);
        exp0(10700, 3);
        idle(6);

        // Reset one cycle after a completed pair discards its in-flight result.
        step(0, 1'b1, 1000, 1'b1, 0);
        idle(1);
        rst0_n = 1'b0;
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        @(negedge clk);
        check("mid reset dut0 o_valid", longint'(if0.o_valid), 0);
        check("mid reset dut0 o_data", longint'(if0.o_data), 0);
        idle(4);
        step(0, 1'b1, 1000, 1'b1, 0);
        idle(4);
        step(0, 1'b1, 0, 1'b1, 1000);
        exp0(1000000, 3);
        idle(6);

        // Throughput: fresh reset, 64 back-to-back pairs against a cross-product model.
        @(posedge clk);
        #1;
        rst0_n = 1'b0;
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        idle(2);
        ip = 32767;
        qp = -32768;
        step(0, 1'b1, ip, 1'b1, qp);
        for (int k = 1; k < 64; k++) begin
            ic = (k == 1) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
            qc = (k == 1) ? 32767 : int'($urandom_range(0, 65535)) - 32768;
            step(0, 1'b1, ic, 1'b1, qc);
            exp0(longint'(ip) * longint'(qc) - longint'(qp) * longint'(ic), 3);
            ip = ic;
            qp = qc;
        end
        idle(8);

        // Decimation by 4: nine +90 degree steps give two sums of four results.
        r = 0;
        for (int k = 0; k < 9; k++) begin
            step(2, 1'b1, vi[k % 4], 1'b1, vq[k % 4]);
            if (k > 0) r++;
            if (r == 4 || r == 8) begin
                if (k % 4 == 0) exp2(4000000, 3);
            end
            idle(2);
        end
        idle(10);

        check("dut0 results outstanding", q0.size(), 0);
        check("dut0 overruns outstanding", ov0.size(), 0);
        check("dut2 results outstanding", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fm_discriminator_dec.md
Name: fm_discriminator_dec

Overview:
- Parametrised successor to freq_demod: a polar FM discriminator on complex baseband, computing the cross product of successive I/Q samples, I[n-1]*Q[n] - Q[n-1]*I[n].
- Adds independent I/Q valid pairing, history priming after reset, overrun flagging, and optional power-of-two integrate-and-dump decimation.
- Sits between the channel-select filter and the audio path of the FM radio.

Parameters:
- IQ_W, 16, signed width of I and Q samples.
- DECIM_LOG2, 0, log2 of decimation ratio; 0 = one output per discriminator result, range 0..6.
- OUT_W, 2*IQ_W+2+DECIM_LOG2, output width (derived; not overridable).

Ports:
- i_clk  in  1  clock, all logic rising-edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_I_data  in  IQ_W  signed in-phase sample.
- i_I_valid  in  1  qualifies i_I_data, single-cycle strobe.
- i_Q_data  in  IQ_W  signed quadrature sample.
- i_Q_valid  in  1  qualifies i_Q_data, single-cycle strobe.
- o_data  out  OUT_W  signed discriminator or decimated sum.
- o_valid  out  1  one-cycle strobe qualifying o_data.
- o_overrun  out  1  one-cycle pulse: a component was overwritten before pairing.

Behaviour:
- Reset: the only reset is synchronous, active-low, sampled on the i_clk rising edge. While i_rst_n=0, o_data=0, o_valid=0, o_overrun=0, the pairing latches are empty, state=PRIME, the history registers are 0, the accumulator is 0 and the decimation counter is 0. Reset mid-operation discards all in-flight pipeline contents; no o_valid follows it.
- Pairing: separate have_I and have_Q latches.
  - Both valids in the same cycle: the pair completes in that cycle (cycle T).
  - One valid only: that component is latched.
  - The pair completes in the cycle the missing component's valid arrives; the latched value is used with the incoming value.
  - The same component's valid again before pairing: the new value overwrites the latched one, o_overrun pulses at T+1, and the latch stays set.
  - On completion both latches clear.
- States:
  - PRIME: a completed pair loads history (I_prev, Q_prev) and moves to RUN; no discriminator result is produced.
  - RUN: each completed pair issues a result using the current history, then the pair becomes the new history.
- Pipeline (pair completes at cycle T):
  - Stage 1 (registered at T+1): p_a = I_prev*Q_cur and p_b = Q_prev*I_cur, each 2*IQ_W signed.
  - Stage 2 (T+2): d = p_a - p_b, sign-extended to 2*IQ_W+2. Full precision; no overflow possible.
  - Stage 3 (T+3): accumulate/output.
- Output when DECIM_LOG2=0: o_data = sign-extended d and o_valid=1 in cycle T+3, i.e. a fixed latency of 3 clocks.
- Output when DECIM_LOG2>0:
  - acc accumulates d; the counter increments per result.
  - On the 2^DECIM_LOG2-th result, o_data = acc + d and o_valid=1 at T+3; acc is loaded with 0 and the counter wraps to 0 in the same cycle.
  - No scaling; the output is the raw sum.
- Throughput: one completed pair per cycle sustained. Back-to-back pairs yield back-to-back o_valid with no bubbles.
- o_data holds its last value while o_valid=0.
- No backpressure: the downstream block must accept every o_valid.

Test Plan:
- Basic (IQ_W=16, DECIM_LOG2=0): pairs (1000,0), (0,1000), (-1000,0) with simultaneous valids 20 cycles apart.
  - The first pair produces no o_valid.
  - o_data=1000000 at 3 cycles after the 2nd pair and again after the 3rd.
  - A clockwise sequence gives -1000000.
- Extremes: prev (-32768,32767), cur (-32768,-32768) -> o_data=2147450880. Prev (-32768,32767), cur (32767,-32768) -> o_data=65535.
- Split valids:
  - I valid at cycle 0, Q valid at cycle 5 -> a single pair completes at cycle 5, result at cycle 8.
  - I at 0, I again at 2, Q at 4 -> o_overrun pulse at 3, and the pair uses the second I.
- Decimation (DECIM_LOG2=2): 9 pairs each rotating +90° at magnitude 1000.
  - Exactly 2 o_valid strobes, each o_data=4000000.
  - Strobe spacing equals 4 pair intervals.
  - No output for the first pair.
- Reset mid-stream:
  - Assert i_rst_n=0 for 1 cycle, 1 cycle after a pair completes -> no o_valid from the in-flight result.
  - The next pair after release re-primes (no output).
  - The following pair produces a normal output 3 cycles later.
- Throughput: 64 back-to-back pairs (valids every cycle) -> 63 consecutive o_valid cycles matching a software cross-product model bit-exactly.
